// File: rtl/bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_counter
// Purpose  : 4-digit BCD up/down event counter with multiplexed display scan,
//            held display snapshot and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_counter #(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        inc,
  input  logic        dir,
  input  logic        hold,
  output logic [15:0] countValue,
  output logic        wrap,
  output logic [3:0]  bcdDigit,
  output logic [3:0]  digitSel
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [15:0]   count;
  logic          wrap_q;
  logic [15:0]   snap;
  logic [PW-1:0] prescale;
  logic [1:0]    scan_idx;

  logic [4:0]    up_carry;
  logic [4:0]    dn_borrow;
  logic [15:0]   up_val;
  logic [15:0]   dn_val;
  logic [15:0]   count_next;
  logic          wrap_next;

  assign up_carry[0]  = 1'b1;
  assign dn_borrow[0] = 1'b1;

  // Per-digit ripple: each digit steps only when every lower digit rolled over.
  for (genvar i = 0; i < 4; i++) begin : g_digit
    logic [3:0] cur;
    assign cur            = count[4*i +: 4];
    assign up_carry[i+1]  = up_carry[i] & (cur == 4'd9);
    assign dn_borrow[i+1] = dn_borrow[i] & (cur == 4'd0);
    assign up_val[4*i +: 4] = !up_carry[i] ? cur :
                              (cur == 4'd9) ? 4'd0 : cur + 4'd1;
    assign dn_val[4*i +: 4] = !dn_borrow[i] ? cur :
                              (cur == 4'd0) ? 4'd9 : cur - 4'd1;
  end

  always_comb begin
    count_next = count;
    wrap_next  = wrap_q;
    if (clear) begin
      count_next = 16'h0000;
      wrap_next  = 1'b0;
    end else if (inc) begin
      if (dir) begin
        count_next = up_val;
        wrap_next  = wrap_q | up_carry[4];
      end else begin
        count_next = dn_val;
        wrap_next  = wrap_q | dn_borrow[4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 16'h0000;
      wrap_q <= 1'b0;
      snap   <= 16'h0000;
    end else begin
      count  <= count_next;
      wrap_q <= wrap_next;
      if (!hold) begin
        snap <= count_next;
      end
    end
  end

  // Display path: digit selection and blanking from the snapshot only.
  logic [3:0] cur_digit;
  logic [3:0] zero_from;
  logic       blank;

  assign zero_from[3] = (snap[15:12] == 4'd0);
  assign zero_from[2] = zero_from[3] & (snap[11:8] == 4'd0);
  assign zero_from[1] = zero_from[2] & (snap[7:4] == 4'd0);
  assign zero_from[0] = zero_from[1] & (snap[3:0] == 4'd0);

  always_comb begin
    cur_digit = snap[3:0];
    case (scan_idx)
      2'd0:    cur_digit = snap[3:0];
      2'd1:    cur_digit = snap[7:4];
      2'd2:    cur_digit = snap[11:8];
      default: cur_digit = snap[15:12];
    endcase
    blank = BLANK_LZ && (scan_idx != 2'd0) && zero_from[scan_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      scan_idx <= 2'd0;
      bcdDigit <= 4'h0;
      digitSel <= 4'b0001;
    end else begin
      if (prescale == PRE_LAST) begin
        prescale <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        prescale <= prescale + PW'(1);
      end
      bcdDigit <= blank ? 4'h0 : cur_digit;
      digitSel <= blank ? 4'b0000 : (4'b0001 << scan_idx);
    end
  end

  assign countValue = count;
  assign wrap       = wrap_q;

endmodule
`default_nettype wire
